sblk_sched: RTL and testbench

Scheduler that sits above N_SBLK `sblk_ctrl` sub-block controllers. It dispatches layer instructions from a single upstream instruction stream to the lowest-indexed free sub-block. It also arbitrates the sub-blocks' one-cycle `act_in_req` pulses onto one shared activation source, using round-robin order. Each grant is held for a whole activation batch, and the source's valid strobe is routed to the granted sub-block only.

---
 rtl/sblk_sched_if.sv | 47 ++++
 rtl/sblk_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sblk_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sblk_sched_if.sv
// sblk_sched_if: bundle of every signal between the scheduler, the upstream
// instruction source, the sub-block controllers and the activation source.
//
//   slave  modport : the scheduler (sblk_sched) side
//   master modport : the environment side (upstream, sub-blocks, source)
//
// Handshake: an upstream instruction transfers on a rising clk_l edge where
// inst_in_vld and inst_in_rdy are both 1; inst_in_data must be stable while
// inst_in_vld is 1. inst_in_rdy never depends on inst_in_vld.
//
// dbg_state exposes the arbiter FSM: 0 = IDLE, 1 = GRANT, 2 = STREAM.
interface sblk_sched_if #(
  parameter int N_SBLK   = 4,
  parameter int WID_SEL  = $clog2(N_SBLK),
  parameter int WID_INST = 14,
  parameter int WID_BEAT = 12
);
  logic [WID_INST-1:0]        inst_in_data;
  logic                       inst_in_vld;
  logic                       inst_in_rdy;
  logic [WID_INST-1:0]        inst_data;
  logic [N_SBLK-1:0]          inst_en;
  logic [N_SBLK-1:0]          status_sblk;
  logic [N_SBLK-1:0]          act_in_req;
  logic [N_SBLK*WID_BEAT-1:0] act_beats;
  logic                       act_src_req;
  logic                       act_src_vld;
  logic [N_SBLK-1:0]          act_in_vld;
  logic [WID_SEL-1:0]         act_sel;
  logic                       busy;
  logic                       err_beat;
  logic [1:0]                 dbg_state;

  modport slave (
    input  inst_in_data, inst_in_vld, status_sblk, act_in_req, act_beats,
           act_src_vld,
    output inst_in_rdy, inst_data, inst_en, act_src_req, act_in_vld, act_sel,
           busy, err_beat, dbg_state
  );

  modport master (
    output inst_in_data, inst_in_vld, status_sblk, act_in_req, act_beats,
           act_src_vld,
    input  inst_in_rdy, inst_data, inst_en, act_src_req, act_in_vld, act_sel,
           busy, err_beat, dbg_state
  );
endinterface

// File: rtl/sblk_sched.sv
// sblk_sched: dispatches upstream instructions to the lowest-indexed free
// sub-block and round-robin arbitrates sub-block activation batch requests
// onto one shared activation source.
//
// Ports:
//   clk_l : clock (single domain)
//   rst   : asynchronous, active-high reset
//   bus   : sblk_sched_if.slave -- instruction in/out, sub-block status and
//           batch requests, activation source request/valid, routed valids,
//           act_sel, busy, err_beat, dbg_state (arbiter FSM state)
module sblk_sched #(
  parameter int N_SBLK   = 4,
  parameter int WID_SEL  = $clog2(N_SBLK),
  parameter int WID_INST = 14,
  parameter int WID_BEAT = 12
) (
  input  logic         clk_l,
  input  logic         rst,
  sblk_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_t;

  function automatic logic [N_SBLK-1:0] onehot(input logic [WID_SEL-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // ---------------------------------------------------------------- dispatch
  logic [WID_INST-1:0]     hold;
  logic                    hold_vld;
  logic [WID_INST-1:0]     inst_data_q;
  logic [N_SBLK-1:0]       inst_en_q;
  logic [N_SBLK-1:0]       pend;
  logic [N_SBLK-1:0][1:0]  pend_age;
  logic [N_SBLK-1:0]       free;
  logic                    free_any;
  logic [WID_SEL-1:0]      free_idx;
  logic                    accept;
  logic                    dispatch;

  assign bus.inst_in_rdy = ~hold_vld;
  assign accept          = bus.inst_in_vld & ~hold_vld;
  // pend covers the gap between inst_en and the sub-block raising its busy flag
  assign free            = ~bus.status_sblk & ~pend;
  assign dispatch        = hold_vld & free_any;

  // Lowest free index: scan downwards so the lowest set bit is written last.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N_SBLK - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_any = 1'b1;
        free_idx = WID_SEL'(i);
      end
    end
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      hold        <= '0;
      hold_vld    <= 1'b0;
      inst_data_q <= '0;
      inst_en_q   <= '0;
    end else begin
      inst_en_q <= '0;
      if (dispatch) begin
        inst_en_q   <= onehot(free_idx);
        inst_data_q <= hold;
        hold_vld    <= 1'b0;
      end else if (accept) begin
        hold     <= bus.inst_in_data;
        hold_vld <= 1'b1;
      end
    end
  end

  // pend[i] drops when the sub-block reports busy, or after 4 quiet cycles
  // so an instruction that never raises busy cannot lock the slot forever.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_age <= '0;
    end else begin
      for (int i = 0; i < N_SBLK; i++) begin
        if (dispatch && free_idx == WID_SEL'(i)) begin
          pend[i]     <= 1'b1;
          pend_age[i] <= 2'd0;
        end else if (pend[i]) begin
          if (bus.status_sblk[i] || pend_age[i] == 2'd3) begin
            pend[i] <= 1'b0;
          end else begin
            pend_age[i] <= pend_age[i] + 2'd1;
          end
        end
      end
    end
  end

  assign bus.inst_data = inst_data_q;
  assign bus.inst_en   = inst_en_q;

  // ----------------------------------------------------------------- arbiter
  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [N_SBLK-1:0]    req_q;
  logic [WID_SEL-1:0]   rr_ptr;
  logic [WID_SEL-1:0]   rr_pick;
  logic [WID_SEL-1:0]   rr_idx;
  logic [WID_SEL-1:0]   act_sel_q;
  logic [WID_BEAT-1:0]  beat_cnt;
  logic [WID_BEAT-1:0]  pick_beats;
  logic                 grant_now;
  logic [N_SBLK-1:0]    grant_clr;
  logic                 err_q;
  logic                 act_src_req_c;
  logic [N_SBLK-1:0]    act_in_vld_c;

  // First requester at or after rr_ptr, cyclically. N_SBLK is a power of two
  // so the WID_SEL-bit addition wraps naturally. Scanning offsets downwards
  // leaves the smallest offset as the final winner.
  always_comb begin
    rr_pick = rr_ptr;
    rr_idx  = '0;
    for (int k = N_SBLK - 1; k >= 0; k--) begin
      rr_idx = rr_ptr + WID_SEL'(k);
      if (req_q[rr_idx]) rr_pick = rr_idx;
    end
  end

  always_comb begin
    pick_beats = '0;
    for (int k = 0; k < N_SBLK; k++) begin
      if (rr_pick == WID_SEL'(k)) pick_beats = bus.act_beats[k*WID_BEAT +: WID_BEAT];
    end
  end

  assign grant_now = (state == ST_IDLE) && (req_q != '0);
  assign grant_clr = grant_now ? onehot(rr_pick) : '0;

  // FSM state register
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_q != '0) state_nxt = ST_GRANT;
      ST_GRANT:  state_nxt = (beat_cnt == '0) ? ST_IDLE : ST_STREAM;
      ST_STREAM: if (bus.act_src_vld && beat_cnt == WID_BEAT'(1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    act_src_req_c = 1'b0;
    act_in_vld_c  = '0;
    case (state)
      ST_GRANT:  act_src_req_c = (beat_cnt != '0);
      ST_STREAM: if (bus.act_src_vld) act_in_vld_c = onehot(act_sel_q);
      default:   ;
    endcase
  end

  // Arbiter datapath: request latches, grant bookkeeping, beat counter.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      rr_ptr    <= '0;
      act_sel_q <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      // a pulse landing on the clearing cycle survives (set wins)
      req_q <= (req_q & ~grant_clr) | bus.act_in_req;
      if (grant_now) begin
        act_sel_q <= rr_pick;
        beat_cnt  <= pick_beats;
        rr_ptr    <= rr_pick + WID_SEL'(1);
      end else if (state == ST_STREAM && bus.act_src_vld) begin
        beat_cnt <= beat_cnt - WID_BEAT'(1);
      end
      if (bus.act_src_vld && state != ST_STREAM) err_q <= 1'b1;
    end
  end

  assign bus.act_src_req = act_src_req_c;
  assign bus.act_in_vld  = act_in_vld_c;
  assign bus.act_sel     = act_sel_q;
  assign bus.err_beat    = err_q;
  assign bus.dbg_state   = state;
  assign bus.busy        = (|bus.status_sblk) | (|pend) | hold_vld | (state != ST_IDLE);

endmodule

// File: tb/tb_sblk_sched.sv
module tb_sblk_sched;
  localparam int N  = 4;
  localparam int WI = 14;
  localparam int WB = 12;

  // ------------------------------------------------------- clock and reset
  logic clk_l = 1'b0;
  logic rst;
  always #5 clk_l = ~clk_l;

  sblk_sched_if #(.N_SBLK(N), .WID_INST(WI), .WID_BEAT(WB)) bus ();
  sblk_sched #(.N_SBLK(N), .WID_INST(WI), .WID_BEAT(WB)) dut (
    .clk_l (clk_l),
    .rst   (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ------------------------------------------------------ reference model
  bit            m_hold_vld;
  logic [WI-1:0] m_hold;
  logic [WI-1:0] m_inst_data;
  logic [N-1:0]  m_inst_en;
  bit            m_pend[N];
  int            m_age[N];
  bit            m_req[N];
  int            m_rr, m_phase, m_sel, m_left;   // phase: 0 idle, 1 grant, 2 stream
  bit            m_err;
  logic [WI-1:0] exp_q[$];

  // sub-block behaviour: busy rises 2 cycles after inst_en, lasts len cycles
  int sb_len[N];
  int rise_at[N];
  int fall_at[N];
  bit rand_len;

  // observations of the DUT (for directed end-of-test checks)
  int            obs_req;
  int            obs_beats[N];
  logic [N-1:0]  en_val_q[$];
  int            en_cyc_q[$];
  int            sel_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: wait budget expired", tag);
  endtask

  task automatic model_reset();
    m_hold_vld = 0; m_hold = '0; m_inst_data = '0; m_inst_en = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_age[i] = 0; m_req[i] = 0; end
    m_rr = 0; m_phase = 0; m_sel = 0; m_left = 0; m_err = 0;
    exp_q.delete();
  endtask

  function automatic bit req_any();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= m_req[i];
    return r;
  endfunction

  function automatic bit pend_any();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= m_pend[i];
    return r;
  endfunction

  // One clock edge of the spec's behaviour, from pre-edge inputs.
  task automatic model_edge();
    int tgt, clr, j;
    bit src;
    if (rst) begin model_reset(); return; end
    tgt = -1;
    if (m_hold_vld)
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !bus.status_sblk[i] && !m_pend[i]) tgt = i;
    for (int i = 0; i < N; i++)
      if (m_pend[i]) begin
        m_age[i]++;
        if (bus.status_sblk[i] || m_age[i] >= 4) m_pend[i] = 0;
      end
    m_inst_en = '0;
    if (tgt >= 0) begin
      m_pend[tgt] = 1; m_age[tgt] = 0;
      m_inst_en[tgt] = 1'b1;
      m_inst_data = m_hold;
      m_hold_vld = 0;
    end else if (!m_hold_vld && bus.inst_in_vld) begin
      m_hold = bus.inst_in_data;
      m_hold_vld = 1;
      exp_q.push_back(bus.inst_in_data);
    end
    src = bus.act_src_vld;
    if (src && m_phase != 2) m_err = 1;
    clr = -1;
    case (m_phase)
      0: if (req_any()) begin
           for (int k = N - 1; k >= 0; k--) begin
             j = (m_rr + k) % N;
             if (m_req[j]) clr = j;
           end
           m_sel = clr;
           m_left = int'(bus.act_beats[clr*WB +: WB]);
           m_rr = (clr + 1) % N;
           m_phase = 1;
         end
      1: m_phase = (m_left == 0) ? 0 : 2;
      default: if (src) begin
           m_left--;
           if (m_left == 0) m_phase = 0;
         end
    endcase
    for (int i = 0; i < N; i++) begin
      if (i == clr) m_req[i] = 0;
      if (bus.act_in_req[i]) m_req[i] = 1;
    end
  endtask

  task automatic sub_tick();
    int len;
    for (int i = 0; i < N; i++) begin
      if (m_inst_en[i]) begin
        len = rand_len ? int'($urandom_range(0, 8)) : sb_len[i];
        rise_at[i] = cyc + 2;
        fall_at[i] = cyc + 2 + len;
      end
      bus.status_sblk[i] = (cyc >= rise_at[i]) && (cyc < fall_at[i]);
    end
  endtask

  task automatic sb_clear();
    for (int i = 0; i < N; i++) begin rise_at[i] = 0; fall_at[i] = 0; end
    bus.status_sblk = '0;
  endtask

  // ----------------------------------------------------------- scoreboard
  task automatic check_all();
    logic [N-1:0] exp_vld;
    exp_vld = '0;
    if (m_phase == 2 && bus.act_src_vld) exp_vld[m_sel] = 1'b1;
    chk("inst_in_rdy", bus.inst_in_rdy, !m_hold_vld);
    chk("inst_en", bus.inst_en, m_inst_en);
    chk("inst_data", bus.inst_data, m_inst_data);
    chk("act_src_req", bus.act_src_req, (m_phase == 1 && m_left != 0));
    chk("act_in_vld", bus.act_in_vld, exp_vld);
    chk("act_sel", bus.act_sel, m_sel);
    chk("busy", bus.busy, ((|bus.status_sblk) || pend_any() || m_hold_vld || m_phase != 0));
    chk("err_beat", bus.err_beat, m_err);
    chk("arb_state", bus.dbg_state, m_phase);
    if (bus.inst_en != '0) begin
      en_val_q.push_back(bus.inst_en);
      en_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_underflow", bus.inst_en, 0);
      else chk("sb_inst_data", bus.inst_data, exp_q.pop_front());
    end
    if (bus.act_src_req) begin
      obs_req++;
      sel_q.push_back(int'(bus.act_sel));
    end
    for (int i = 0; i < N; i++) obs_beats[i] += int'(bus.act_in_vld[i]);
  endtask

  // ----------------------------------------------------------- driver tasks
  task automatic step();
    #1 check_all();
    @(posedge clk_l);
    model_edge();
    @(negedge clk_l);
    cyc++;
    sub_tick();
  endtask

  // one cycle with request pulses; the source streams only in STREAM
  task automatic cycle(logic [N-1:0] mask, bit gap);
    bus.act_in_req  = mask;
    bus.act_src_vld = (m_phase == 2) && (!gap || ($urandom_range(0, 1) == 1));
    step();
    bus.act_in_req  = '0;
    bus.act_src_vld = 1'b0;
  endtask

  task automatic offer(logic [WI-1:0] data);
    bit acc;
    bus.inst_in_vld  = 1'b1;
    bus.inst_in_data = data;
    for (int n = 0; n < 200; n++) begin
      acc = !m_hold_vld;
      cycle('0, 0);
      if (acc) return;
    end
    timeout_fail("offer");
  endtask

  function automatic bit quiet();
    bit q = (m_phase == 0) && !req_any() && !m_hold_vld && !pend_any();
    for (int i = 0; i < N; i++) q &= (cyc >= fall_at[i]);
    return q;
  endfunction

  task automatic settle(int budget, bit gap);
    bus.inst_in_vld = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (quiet()) return;
      cycle('0, gap);
    end
    timeout_fail("settle");
  endtask

  task automatic set_beats(int i, int v);
    bus.act_beats[i*WB +: WB] = WB'(v);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin : main
    int base, r0, b0, b1, b2, nsel, n;
    logic [N-1:0] exp_fill[5];
    exp_fill[0] = 4'b0001; exp_fill[1] = 4'b0010; exp_fill[2] = 4'b0100;
    exp_fill[3] = 4'b1000; exp_fill[4] = 4'b0100;

    rst = 1'b1;
    bus.inst_in_vld = 1'b0; bus.inst_in_data = '0; bus.status_sblk = '0;
    bus.act_in_req = '0; bus.act_beats = '0; bus.act_src_vld = 1'b0;
    rand_len = 0;
    for (int i = 0; i < N; i++) begin
      sb_len[i] = 20; rise_at[i] = 0; fall_at[i] = 0; obs_beats[i] = 0;
    end
    obs_req = 0;
    model_reset();
    repeat (2) @(negedge clk_l);
    repeat (2) step();            // reset values checked here
    rst = 1'b0;
    step();

    // Dispatch fill: sub-block 2 finishes first and takes the 5th instruction
    for (int i = 0; i < N; i++) sb_len[i] = 40;
    sb_len[2] = 10;
    base = en_val_q.size();
    for (int k = 0; k < 5; k++) offer(WI'($urandom_range(0, 16383)));
    bus.inst_in_vld = 1'b0;
    chk("fill_hold_rdy", bus.inst_in_rdy, 0);
    settle(200, 0);
    chk("fill_count", en_val_q.size(), base + 5);
    if (en_val_q.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) chk("fill_en", en_val_q[base+k], exp_fill[k]);
      for (int k = 1; k < 4; k++) chk("fill_spacing", en_cyc_q[base+k] - en_cyc_q[base+k-1], 2);
      chk("fill_fifth_wait", en_cyc_q[base+4] - en_cyc_q[base+2], 13);
    end

    // Pending guard: second instruction must avoid sub-block 0
    for (int i = 0; i < N; i++) sb_len[i] = 12;
    base = en_val_q.size();
    offer(WI'($urandom_range(0, 16383)));
    offer(WI'($urandom_range(0, 16383)));
    settle(100, 0);
    chk("guard_count", en_val_q.size(), base + 2);
    if (en_val_q.size() >= base + 2) begin
      chk("guard_first", en_val_q[base], 4'b0001);
      chk("guard_second", en_val_q[base+1], 4'b0010);
    end

    // Round-robin: 0 and 2 together, then 0 again during stream 2
    set_beats(0, 8); set_beats(2, 8);
    r0 = obs_req; b0 = obs_beats[0]; b2 = obs_beats[2]; nsel = sel_q.size();
    cycle(4'b0101, 0);
    n = 0;
    while (!(m_phase == 2 && m_sel == 2) && n < 60) begin cycle('0, 0); n++; end
    if (n >= 60) timeout_fail("rr_reach_stream2");
    cycle(4'b0001, 0);
    settle(100, 0);
    chk("rr_src_req_count", obs_req - r0, 3);
    chk("rr_beats0", obs_beats[0] - b0, 16);
    chk("rr_beats2", obs_beats[2] - b2, 8);
    chk("rr_grants", sel_q.size() - nsel, 3);
    if (sel_q.size() >= nsel + 3) begin
      chk("rr_order0", sel_q[nsel], 0);
      chk("rr_order1", sel_q[nsel+1], 2);
      chk("rr_order2", sel_q[nsel+2], 0);
    end

    // Boundary: zero-beat batch on 3, then a gapped 5-beat batch on 1
    set_beats(3, 0);
    r0 = obs_req;
    cycle(4'b1000, 0);
    settle(20, 0);
    chk("zero_no_src_req", obs_req - r0, 0);
    chk("zero_act_sel", bus.act_sel, 3);
    chk("zero_idle", bus.dbg_state, 0);
    set_beats(1, 5);
    r0 = obs_req; b1 = obs_beats[1];
    cycle(4'b0010, 1);
    settle(200, 1);
    chk("gap_beats1", obs_beats[1] - b1, 5);
    chk("gap_src_req", obs_req - r0, 1);

    // Stray beat in IDLE
    bus.act_src_vld = 1'b1;
    step();
    bus.act_src_vld = 1'b0;
    chk("stray_err", bus.err_beat, 1);
    repeat (3) step();
    chk("stray_err_sticky", bus.err_beat, 1);

    // Reset mid-STREAM after 3 of 8 beats
    set_beats(1, 8);
    b1 = obs_beats[1];
    cycle(4'b0010, 0);
    n = 0;
    while (obs_beats[1] - b1 < 3 && n < 60) begin cycle('0, 0); n++; end
    if (n >= 60) timeout_fail("rst_reach_beat3");
    rst = 1'b1;
    model_reset();
    sb_clear();
    step();                        // reset values checked in this same cycle
    chk("rst_mid_state", bus.dbg_state, 0);
    chk("rst_mid_err", bus.err_beat, 0);
    rst = 1'b0;
    step();
    b1 = obs_beats[1];
    cycle(4'b0010, 0);
    settle(100, 0);
    chk("rst_fresh_beats", obs_beats[1] - b1, 8);

    // Randomized traffic against the model
    rand_len = 1;
    for (int i = 0; i < N; i++) set_beats(i, int'($urandom_range(0, 6)));
    for (int c = 0; c < 1500; c++) begin
      bus.inst_in_vld  = ($urandom_range(0, 2) != 0);
      bus.inst_in_data = WI'($urandom_range(0, 16383));
      if ($urandom_range(0, 19) == 0) set_beats(int'($urandom_range(0, N-1)), int'($urandom_range(0, 6)));
      cycle(($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0, 1);
    end
    settle(400, 1);
    rand_len = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
